// File: rtl/count_output_latch.sv
// count_output_latch
// ------------------
// Read side of one 8254 counter. Holds the output latch (OL), which follows
// the counting element until a counter-latch command freezes it. Also holds
// the read-back status latch and the LSB/MSB byte pointer. On each CPU read
// it returns the selected byte on databus.
//
// Ports
//   clk            system clock
//   reset_n        synchronous active-low reset
//   current_count  live counting-element value
//   status_in      live status byte {OUT, NULL_COUNT, RW[1:0], M[2:0], BCD}
//   rw_mode        access mode: 01 LSB, 10 MSB, 11 LSB then MSB, 00 as 01
//   mode_write     control word written to this counter (strobe)
//   latch_count    counter-latch / read-back count-latch command (strobe)
//   latch_status   read-back status-latch command (strobe)
//   read           CPU read of this counter (strobe)
//   databus        byte returned by the most recent read
//   count_latched  OL frozen, awaiting read-out
//   status_latched status byte latched, awaiting read-out
module count_output_latch #(
    parameter int COUNT_WIDTH = 16,
    parameter int DATA_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [COUNT_WIDTH-1:0] current_count,
    input  logic [DATA_WIDTH-1:0]  status_in,
    input  logic [1:0]             rw_mode,
    input  logic                   mode_write,
    input  logic                   latch_count,
    input  logic                   latch_status,
    input  logic                   read,
    output logic [DATA_WIDTH-1:0]  databus,
    output logic                   count_latched,
    output logic                   status_latched
);

    logic [COUNT_WIDTH-1:0] ol;
    logic [DATA_WIDTH-1:0]  status_reg;
    logic                   ptr_msb;

    logic word_mode;
    logic sel_msb;
    logic count_read;
    logic status_read;
    logic count_release;
    logic count_free;
    logic status_free;

    function automatic logic [DATA_WIDTH-1:0] pick_byte(
        input logic [COUNT_WIDTH-1:0] value,
        input logic                   hi
    );
        return hi ? value[2*DATA_WIDTH-1:DATA_WIDTH] : value[DATA_WIDTH-1:0];
    endfunction

    always_comb begin
        word_mode     = (rw_mode == 2'b11);
        sel_msb       = (rw_mode == 2'b10) || (word_mode && ptr_msb);
        // A pending status byte always takes the read ahead of the count.
        status_read   = read && status_latched;
        count_read    = read && !status_latched;
        // The read that completes the byte sequence releases the count latch.
        count_release = count_read && (!word_mode || ptr_msb);
        // A new latch may be taken when none is held or when this edge's
        // read releases the one that is held. A set beats a release.
        count_free    = !count_latched || count_release;
        status_free   = !status_latched || status_read;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ol             <= '0;
            status_reg     <= '0;
            ptr_msb        <= 1'b0;
            databus        <= '0;
            count_latched  <= 1'b0;
            status_latched <= 1'b0;
        end else if (mode_write) begin
            // Reprogramming drops any pending latch and restarts at LSB.
            // databus keeps the last byte read.
            ol             <= current_count;
            ptr_msb        <= 1'b0;
            count_latched  <= 1'b0;
            status_latched <= 1'b0;
        end else begin
            if (status_read) begin
                databus <= status_reg;
            end else if (count_read) begin
                databus <= pick_byte(ol, sel_msb);
                if (word_mode) begin
                    ptr_msb <= !ptr_msb;
                end
            end

            // OL tracks while unlatched. It takes a fresh snapshot on a
            // latch command that is accepted. On a plain release it holds
            // for this edge and resumes tracking on the following one.
            if (!count_latched || (latch_count && count_free)) begin
                ol <= current_count;
            end
            count_latched <= (count_latched && !count_release) || latch_count;

            if (latch_status && status_free) begin
                status_reg <= status_in;
            end
            status_latched <= (status_latched && !status_read) || latch_status;
        end
    end

endmodule

// File: doc/count_output_latch.md
Name: count_output_latch

Overview:
- Read-side counterpart of the count register: the count register loads the initial count from the data bus, and this block returns a counter's live or latched count and status byte back onto the data bus.
- Implements the 8254 output latch (OL), the counter-latch command, the read-back status latch, and the LSB/MSB read byte pointer.
- One instance per counter, between the counting element and the bus-interface read mux.

Parameters:
- COUNT_WIDTH, 16, width of counting element and output latch (fixed at 2 bytes)
- DATA_WIDTH, 8, data bus width

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset, sampled on rising clk
- current_count  in  16  live counting-element value
- status_in  in  8  live status byte {OUT, NULL_COUNT, RW[1:0], M[2:0], BCD}
- rw_mode  in  2  programmed access mode: 01 LSB only, 10 MSB only, 11 LSB then MSB, 00 treated as 01
- mode_write  in  1  one-cycle strobe: control word written to this counter
- latch_count  in  1  one-cycle strobe: counter-latch or read-back count-latch command
- latch_status  in  1  one-cycle strobe: read-back status-latch command
- read  in  1  one-cycle strobe: CPU read of this counter (already synchronised)
- databus  out  8  byte returned by the most recent read
- count_latched  out  1  OL frozen, awaiting read
- status_latched  out  1  status byte latched, awaiting read

Behaviour:
Reset (reset_n=0 at a clk edge):
- OL=0, databus=0, count_latched=0, status_latched=0, status register=0, byte pointer=LSB.
- Reset takes priority over every other input.

Output latch (OL):
- While count_latched=0, OL <= current_count every cycle (transparent, one-cycle lag).
- latch_count with count_latched=0: OL <= current_count and count_latched <= 1; OL then holds.
- latch_count with count_latched=1: ignored. The first latch wins until it is read out.

Status latch:
- latch_status with status_latched=0: status register <= status_in, status_latched <= 1.
- latch_status with status_latched=1: ignored.

Read (latency 1 cycle; databus updates on the edge where read=1 and holds until the next read):
- status_latched=1: databus <= status register, status_latched <= 0. Byte pointer and count latch are unchanged.
- Otherwise, databus <= byte selected by rw_mode and the pointer:
  - mode 01/00: OL[7:0]
  - mode 10: OL[15:8]
  - mode 11: OL[7:0] if pointer=LSB, else OL[15:8]; pointer toggles on every count read, latched or not.
- Count-latch release, on the read that completes the sequence:
  - modes 01/10/00: any count read.
  - mode 11: the MSB read.
  - On release, count_latched <= 0 and OL resumes tracking on the next edge.

mode_write:
- Clears count_latched and status_latched, sets pointer=LSB, OL resumes tracking.
- databus is unchanged.
- Priority: above latch_count, latch_status and read.

Simultaneous events (same edge):
- latch_count + read:
  - The read returns the pre-edge OL value and advances the pointer.
  - The latch is set; setting beats releasing, so count_latched=1 afterwards.
- latch_status + read: the read takes the normal count path; the status latch is set afterwards.
- latch_count + latch_status: both latches are set; subsequent reads return status first, then the count bytes.

Other rules:
- Mid-sequence latch in mode 11 (pointer=MSB when the latch is set): the next read returns the latched MSB and releases the latch. The pointer is not reset by latch commands.
- rw_mode changes without mode_write: undefined. The control path always pulses mode_write.
- No arithmetic is performed: the OL holds raw binary or BCD exactly as presented.

Test Plan:
- Mode 11, current_count=16'h1234 held, pulse latch_count; change current_count to 16'h9999; read twice.
  → databus=8'h34 then 8'h12; count_latched=1 after the first read, 0 after the second; OL=16'h9999 two cycles later.
- Mode 01, latch at 16'hABCD, second latch_count at 16'h0001 before reading, then read.
  → databus=8'hCD; second latch ignored; count_latched=0.
- Mode 11, status_in=8'hB6, latch_count at 16'h0F0E and latch_status same cycle; read three times.
  → databus=8'hB6, 8'h0E, 8'h0F; status_latched drops after read 1, count_latched after read 3.
- Mode 11, one unlatched read (pointer→MSB), then latch_count at 16'h5A5A, mode_write, read.
  → both latched flags 0 after mode_write; read returns the LSB of the live count; pointer=LSB restart verified.
- Mode 10, latch at 16'h7700; read and latch_count in the same cycle with current_count=16'h1100; read again.
  → first read returns 8'h77 and count_latched stays 1; second read returns 8'h11.
- Latch at 16'h4321 in mode 11, one read, reset_n=0 for one cycle.
  → databus=0, both flags 0, OL=0; after reset the next read returns the live LSB.
